eca_rule_engine: RTL and testbench

//   Parametrised elementary-cellular-automaton engine generalising the fixed 3-input truth-table gates.

---
 rtl/eca_rule_engine.sv | 115 +++++++++++
 tb/tb_eca_rule_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/eca_rule_engine.sv
`default_nettype none
// ============================================================================
// Module      : eca_rule_engine
// Description : Elementary cellular automaton stepping a WIDTH-cell state under
//               a loadable 8-bit rule; ECA_WRAP_EN selects a periodic boundary.
// Revision    : 1.0  initial release
// ============================================================================
module eca_rule_engine #(
   parameter int         WIDTH        = 16,
   parameter int         STEP_W       = 8,
   parameter logic [7:0] RULE_DEFAULT = 8'h9A
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rule_wr,
   input  logic [7:0]        rule_din,
   input  logic              seed_valid,
   output logic              seed_ready,
   input  logic [WIDTH-1:0]  seed_data,
   input  logic [STEP_W-1:0] run_steps,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] step_count,
   output logic [WIDTH-1:0]  state_q,
   output logic [7:0]        rule_q
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_fsm;
   logic [WIDTH-1:0]    r_state;
   logic [7:0]          r_rule;
   logic [STEP_W-1:0]   r_count;
   logic [STEP_W-1:0]   r_remain;
   logic                r_busy;
   logic                r_done;

   logic [WIDTH+1:0]    w_ext;
   logic [WIDTH-1:0]    w_next;

   // State padded with one boundary cell on each side: {left of MSB, state, right of LSB}
`ifdef ECA_WRAP_EN
   assign w_ext = {r_state[0], r_state, r_state[WIDTH-1]};
`else
   assign w_ext = {1'b0, r_state, 1'b0};
`endif

   // Rule MSB serves neighbourhood 000, so the lookup index is the inverted {l,c,r}
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic [2:0] w_nbr;
      assign w_nbr     = w_ext[i+2:i];
      assign w_next[i] = r_rule[~w_nbr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm    <= S_IDLE;
         r_state  <= '0;
         r_rule   <= RULE_DEFAULT;
         r_count  <= '0;
         r_remain <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_fsm)
            S_IDLE: begin
               if (rule_wr) r_rule <= rule_din;
               if (seed_valid) begin
                  r_state  <= seed_data;
                  r_count  <= '0;
                  r_remain <= run_steps;
                  r_busy   <= 1'b1;
                  if (run_steps != '0) begin
                     r_fsm <= S_RUN;
                  end else begin
                     r_fsm  <= S_DONE;
                     r_done <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               r_state  <= w_next;
               r_count  <= r_count + STEP_W'(1);
               r_remain <= r_remain - STEP_W'(1);
               if (r_remain == STEP_W'(1)) begin
                  r_fsm  <= S_DONE;
                  r_done <= 1'b1;
               end
            end
            S_DONE: begin
               r_fsm  <= S_IDLE;
               r_busy <= 1'b0;
            end
            default: begin
               r_fsm  <= S_IDLE;
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign seed_ready = (r_fsm == S_IDLE);
   assign busy       = r_busy;
   assign done       = r_done;
   assign step_count = r_count;
   assign state_q    = r_state;
   assign rule_q     = r_rule;

endmodule
`default_nettype wire

// File: tb/tb_eca_rule_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_eca_rule_engine
// Description : Randomised scoreboard bench for eca_rule_engine at WIDTH=8.
// Revision    : 1.0  initial release
// ============================================================================
module tb_eca_rule_engine;

   localparam int W = 8;
`ifdef ECA_WRAP_EN
   localparam bit c_wrap = 1'b1;
`else
   localparam bit c_wrap = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         rule_wr = 1'b0;
   logic [7:0]   rule_din = '0;
   logic         seed_valid = 1'b0;
   logic         seed_ready;
   logic [W-1:0] seed_data = '0;
   logic [7:0]   run_steps = '0;
   logic         busy;
   logic         done;
   logic [7:0]   step_count;
   logic [W-1:0] state_q;
   logic [7:0]   rule_q;

   eca_rule_engine #(.WIDTH(W), .STEP_W(8), .RULE_DEFAULT(8'h9A)) dut (
      .clk(clk), .rst_n(rst_n), .rule_wr(rule_wr), .rule_din(rule_din),
      .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_data(seed_data),
      .run_steps(run_steps), .busy(busy), .done(done), .step_count(step_count),
      .state_q(state_q), .rule_q(rule_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         edge_no;
      logic [7:0] st;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad = 0;
   int         edge_cnt = 0;
   logic [7:0] mdl_rule = 8'h9A;

   always @(posedge clk) edge_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One generation computed directly from the neighbourhood definition
   function automatic logic [7:0] gen(input logic [7:0] s, input logic [7:0] rule);
      logic [7:0] o;
      int l, c, r, idx;
      for (int i = 0; i < W; i++) begin
         c = int'(s[i]);
         if (i == 0) r = c_wrap ? int'(s[W-1]) : 0;
         else        r = int'(s[i-1]);
         if (i == W-1) l = c_wrap ? int'(s[0]) : 0;
         else          l = int'(s[i+1]);
         idx  = 4*l + 2*c + r;
         o[i] = rule[7-idx];
      end
      return o;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding run
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 want no pending run");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_edge", edge_cnt, e.edge_no);
            chk("done_state", {24'd0, state_q}, {24'd0, e.st});
            chk("done_steps", {24'd0, step_count}, {24'd0, e.cnt});
            chk("done_busy", {31'd0, busy}, 32'd1);
         end
      end
   end

   // Called at a falling edge; holds valid until accepted, returns at the falling edge after accept
   task automatic send(input logic [7:0] seed, input int n, input bit wr, input logic [7:0] rule);
      int guard;
      logic [7:0] s;
      exp_t e;
      seed_valid = 1'b1;
      seed_data  = seed;
      run_steps  = n[7:0];
      rule_wr    = wr;
      rule_din   = rule;
      guard = 0;
      while (!seed_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("seed_accept", {31'd0, seed_ready}, 32'd1);
      if (seed_ready) begin
         if (wr) mdl_rule = rule;
         s = seed;
         for (int i = 0; i < n; i++) s = gen(s, mdl_rule);
         e.edge_no = edge_cnt + 1 + n;
         e.st      = s;
         e.cnt     = n[7:0];
         sb.push_back(e);
      end
      @(negedge clk);
      seed_valid = 1'b0;
      rule_wr    = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (!seed_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("idle_timeout", {31'd0, seed_ready}, 32'd1);
   endtask

   initial begin
      // Reset asserted mid-cycle
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", {24'd0, state_q}, 32'h0);
      chk("rst_rule", {24'd0, rule_q}, 32'h9A);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_steps", {24'd0, step_count}, 32'd0);
      #14 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, seed_ready}, 32'd1);

      // Default rule, single step
      send(8'h10, 1, 1'b0, 8'h00);
      wait_idle();
      chk("t2_state", {24'd0, state_q}, 32'hCF);
      chk("t2_steps", {24'd0, step_count}, 32'd1);

      // XOR rule, two generations traced
      send(8'h10, 2, 1'b1, 8'h5A);
      chk("t3_gen0", {24'd0, state_q}, 32'h10);
      @(negedge clk);
      chk("t3_gen1", {24'd0, state_q}, 32'h28);
      chk("t3_ready_busy", {31'd0, seed_ready}, 32'd0);
      @(negedge clk);
      chk("t3_gen2", {24'd0, state_q}, 32'h44);
      chk("t3_busy", {31'd0, busy}, 32'd1);
      wait_idle();

      // Boundary behaviour
      send(8'h01, 1, 1'b0, 8'h00);
      wait_idle();
      chk("t4_boundary", {24'd0, state_q}, c_wrap ? 32'h82 : 32'h02);

      // Zero-length run completes the cycle after accept
      send(8'hA5, 0, 1'b0, 8'h00);
      chk("t5_zero_done", {31'd0, done}, 32'd1);
      chk("t5_zero_state", {24'd0, state_q}, 32'hA5);
      chk("t5_zero_steps", {24'd0, step_count}, 32'd0);
      wait_idle();

      // Rule write during a run is ignored
      send(8'h3C, 5, 1'b0, 8'h00);
      rule_wr  = 1'b1;
      rule_din = 8'h00;
      @(negedge clk);
      rule_wr = 1'b0;
      wait_idle();
      chk("t5_rule_kept", {24'd0, rule_q}, {24'd0, mdl_rule});

      // Reset mid-run aborts with no done pulse
      send(8'h10, 10, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      sb.delete();
      mdl_rule = 8'h9A;
      #1;
      chk("t6_state", {24'd0, state_q}, 32'h0);
      chk("t6_rule", {24'd0, rule_q}, 32'h9A);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_done", {31'd0, done}, 32'd0);
      chk("t6_steps", {24'd0, step_count}, 32'd0);
      #5 rst_n = 1'b1;
      @(negedge clk);
      send(8'h10, 1, 1'b0, 8'h00);
      wait_idle();
      chk("t6_rerun", {24'd0, state_q}, 32'hCF);

      // Randomised runs, seeds often offered while still busy
      for (int k = 0; k < 40; k++) begin
         logic [7:0] sd, rl;
         int n;
         bit wr;
         sd = 8'($urandom);
         rl = 8'($urandom);
         n  = int'($urandom_range(0, 12));
         wr = 1'($urandom_range(0, 1));
         send(sd, n, wr, rl);
         if ($urandom_range(0, 1) == 1 && !seed_ready) begin
            rule_wr  = 1'b1;
            rule_din = 8'($urandom);
            @(negedge clk);
            rule_wr = 1'b0;
         end
         if ($urandom_range(0, 2) == 0) wait_idle();
      end
      wait_idle();
      repeat (3) @(negedge clk);
      chk("rule_final", {24'd0, rule_q}, {24'd0, mdl_rule});
      chk("sb_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
